// File: rtl/fetch_mem_sequencer.sv
// fetch_mem_sequencer: shares one memory bus between instruction fetch and load/store for an RV32I datapath.
// Ports: clk/reset_n (async active-low); PC, ALUResult, WriteData, MemRead, MemWrite from the datapath;
// Instr, ReadData latched words; stall holds PC; commit is a one-cycle retire strobe;
// bus_req/bus_we/bus_addr/bus_wdata/bus_rdata/bus_ack form the shared memory bus;
// bus_err is a sticky timeout flag.
// Optional: define MEM_TIMEOUT_EN to halt after TIMEOUT_CYCLES cycles without bus_ack.
module fetch_mem_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] PC,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] Instr,
  output logic [31:0] ReadData,
  output logic        stall,
  output logic        commit,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);
  typedef enum logic [2:0] {
    IDLE, FETCH, EXEC, DATA, WB
`ifdef MEM_TIMEOUT_EN
    , HALT
`endif
  } state_t;
  state_t state;
`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       err_q;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      Instr    <= 32'h0000_0013;
      ReadData <= '0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE:  state <= FETCH;
        FETCH: if (bus_ack) begin
          Instr <= bus_rdata;
          state <= EXEC;
        end
        EXEC:  state <= (MemRead || MemWrite) ? DATA : FETCH;
        // a load+store decode is treated as a store, so ReadData keeps its value
        DATA:  if (bus_ack) begin
          if (MemRead && !MemWrite) ReadData <= bus_rdata;
          state <= WB;
        end
        WB:    state <= FETCH;
`ifdef MEM_TIMEOUT_EN
        HALT:  state <= HALT;
`endif
        default: state <= IDLE;
      endcase
`ifdef MEM_TIMEOUT_EN
      // counter is zero whenever a bus phase is entered, counts unacked cycles inside it
      wait_cnt <= ((state == FETCH || state == DATA) && !bus_ack) ? wait_cnt + 8'd1 : '0;
      if ((state == FETCH || state == DATA) && !bus_ack && wait_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
        state <= HALT;
        err_q <= 1'b1;
      end
`endif
    end
  end
  always_comb begin
    bus_req   = state == FETCH || state == DATA;
    bus_we    = state == DATA && MemWrite;
    bus_addr  = state == FETCH ? PC : state == DATA ? ALUResult : '0;
    bus_wdata = state == DATA ? WriteData : '0;
    commit    = state == WB || (state == EXEC && !MemRead && !MemWrite);
    stall     = !commit;
  end
`ifdef MEM_TIMEOUT_EN
  assign bus_err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = TIMEOUT_CYCLES != 0;
  assign bus_err = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_mem_sequencer.sv
// tb_fetch_mem_sequencer: directed-vector bench for fetch_mem_sequencer with hand-computed expectations.
module tb_fetch_mem_sequencer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] PC, ALUResult, WriteData, bus_rdata;
  logic        MemWrite, MemRead, bus_ack;
  logic [31:0] Instr, ReadData, bus_addr, bus_wdata;
  logic        stall, commit, bus_req, bus_we, bus_err;
  int n_vec = 0;
  int n_bad = 0;
  fetch_mem_sequencer dut (
    .clk(clk), .reset_n(reset_n), .PC(PC), .ALUResult(ALUResult), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .Instr(Instr), .ReadData(ReadData),
    .stall(stall), .commit(commit), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .bus_err(bus_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset_n = 1'b0; PC = '0; ALUResult = '0; WriteData = '0; bus_rdata = '0;
    MemWrite = 1'b0; MemRead = 1'b0; bus_ack = 1'b0;
    tick(); tick();
    chk("rst_instr", Instr, 32'h13);
    chk("rst_rdata", ReadData, 0);
    chk("rst_stall", stall, 1);
    chk("rst_commit", commit, 0);
    chk("rst_req", bus_req, 0);
    chk("rst_we", bus_we, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_err", bus_err, 0);
    // addi with zero-wait fetch
    bus_ack = 1'b1; bus_rdata = 32'h0050_0093;
    reset_n = 1'b1;
    chk("idle_req", bus_req, 0);
    tick();
    chk("c1_req", bus_req, 1);
    chk("c1_addr", bus_addr, 0);
    chk("c1_we", bus_we, 0);
    chk("c1_commit", commit, 0);
    tick();
    chk("c2_instr", Instr, 32'h0050_0093);
    chk("c2_commit", commit, 1);
    chk("c2_stall", stall, 0);
    chk("c2_req", bus_req, 0);
    bus_ack = 1'b0;
    @(posedge clk); PC = 32'd4; #1;
    chk("c3_commit", commit, 0);
    chk("c3_req", bus_req, 1);
    chk("c3_addr", bus_addr, 4);
    // load with three wait states
    bus_ack = 1'b1; bus_rdata = 32'h1000_2083; MemRead = 1'b1; ALUResult = 32'h100;
    tick();
    bus_ack = 1'b0;
    chk("ld_exec_instr", Instr, 32'h1000_2083);
    chk("ld_exec_stall", stall, 1);
    chk("ld_exec_commit", commit, 0);
    chk("ld_exec_req", bus_req, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ld_wait_req", bus_req, 1);
      chk("ld_wait_addr", bus_addr, 32'h100);
      chk("ld_wait_we", bus_we, 0);
      chk("ld_wait_commit", commit, 0);
    end
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    tick();
    chk("ld_wb_rdata", ReadData, 32'hDEAD_BEEF);
    chk("ld_wb_commit", commit, 1);
    chk("ld_wb_stall", stall, 0);
    chk("ld_wb_req", bus_req, 0);
    // spurious ack during WB
    bus_rdata = 32'hBAD0_BAD0;
    @(posedge clk); bus_ack = 1'b0; PC = 32'd8; MemRead = 1'b0; #1;
    chk("wb_spur_rdata", ReadData, 32'hDEAD_BEEF);
    chk("wb_spur_instr", Instr, 32'h1000_2083);
    chk("ld_post_commit", commit, 0);
    chk("st_fetch_addr", bus_addr, 8);
    // store with two wait states and a spurious ack in EXEC
    bus_ack = 1'b1; bus_rdata = 32'h2020_A023;
    MemWrite = 1'b1; ALUResult = 32'h204; WriteData = 32'h1234_5678;
    tick();
    chk("st_exec_instr", Instr, 32'h2020_A023);
    chk("st_exec_stall", stall, 1);
    chk("st_exec_commit", commit, 0);
    bus_rdata = 32'hBAD0_BAD0;
    @(posedge clk); bus_ack = 1'b0; #1;
    chk("exec_spur_instr", Instr, 32'h2020_A023);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      chk("st_wait_req", bus_req, 1);
      chk("st_wait_we", bus_we, 1);
      chk("st_wait_addr", bus_addr, 32'h204);
      chk("st_wait_wdata", bus_wdata, 32'h1234_5678);
    end
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    tick();
    chk("st_wb_rdata", ReadData, 32'hDEAD_BEEF);
    chk("st_wb_commit", commit, 1);
    chk("st_wb_we", bus_we, 0);
    chk("st_wb_wdata", bus_wdata, 0);
    chk("st_wb_addr", bus_addr, 0);
    bus_ack = 1'b0;
    @(posedge clk); PC = 32'd12; MemWrite = 1'b0; #1;
    chk("st_next_addr", bus_addr, 12);
    // reset during a load data wait
    bus_ack = 1'b1; bus_rdata = 32'h00C0_2103; MemRead = 1'b1; ALUResult = 32'h300;
    tick();
    bus_ack = 1'b0;
    tick();
    chk("rd_data_req", bus_req, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_req", bus_req, 0);
    chk("arst_stall", stall, 1);
    chk("arst_instr", Instr, 32'h13);
    chk("arst_rdata", ReadData, 0);
    chk("arst_addr", bus_addr, 0);
    tick();
    reset_n = 1'b1; MemRead = 1'b0; PC = 32'h40;
    #1;
    chk("rel_idle_req", bus_req, 0);
    chk("rel_idle_stall", stall, 1);
    tick();
    chk("rel_fetch_req", bus_req, 1);
    chk("rel_fetch_addr", bus_addr, 32'h40);
    tick();
    chk("rel_fetch_hold", bus_req, 1);
    chk("rel_fetch_commit", commit, 0);
    // MemRead and MemWrite together behave as a store
    bus_ack = 1'b1; bus_rdata = 32'h0000_0003;
    MemRead = 1'b1; MemWrite = 1'b1; ALUResult = 32'h80; WriteData = 32'h55AA;
    tick();
    bus_ack = 1'b0;
    chk("both_exec_commit", commit, 0);
    tick();
    chk("both_we", bus_we, 1);
    chk("both_wdata", bus_wdata, 32'h55AA);
    bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
    tick();
    bus_ack = 1'b0;
    chk("both_rdata", ReadData, 0);
    chk("both_commit", commit, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_mem_sequencer.md
# fetch_mem_sequencer

Multi-cycle sequencer that shares one memory bus between instruction fetch and load/store access for the RV32I datapath. Per instruction it fetches from `PC` and latches the instruction word. If the decoded instruction is a load or store, it runs a data phase. It holds the datapath's `stall` high until the instruction commits, and emits a one-cycle commit strobe that gates PC update and register-file write.

## Interface
- `TIMEOUT_CYCLES`, 64: bus wait limit per phase, in cycles; used only with `MEM_TIMEOUT_EN`.
- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  reset; asynchronous, active-low
- `PC`  in  32  current program counter from the datapath
- `ALUResult`  in  32  load/store byte address
- `WriteData`  in  32  store data (rs2)
- `MemWrite`  in  1  decoded store
- `MemRead`  in  1  decoded load (`ResultSrc`==2'b01)
- `Instr`  out  32  latched instruction word, to the datapath and decoder
- `ReadData`  out  32  latched load data
- `stall`  out  1  1 holds `PC`
- `commit`  out  1  one-cycle strobe; the register-file write enable is `RegWrite & commit`
- `bus_req`  out  1  bus request
- `bus_we`  out  1  1 = write
- `bus_addr`  out  32  bus address
- `bus_wdata`  out  32  bus write data
- `bus_rdata`  in  32  bus read data, valid with `bus_ack`
- `bus_ack`  in  1  transfer complete
- `bus_err`  out  1  sticky timeout flag; tied 0 without `MEM_TIMEOUT_EN`

## Operation
- States: IDLE, FETCH, EXEC, DATA, WB, HALT (HALT exists only with the macro).
- IDLE: `stall`=1, `bus_req`=0. Always goes to FETCH on the next edge.
- FETCH: `bus_req`=1, `bus_we`=0, `bus_addr`=`PC`.
  - On `bus_ack`: `Instr`<=`bus_rdata`, go to EXEC.
- EXEC: `Instr` is valid and the datapath decodes it combinationally.
  - Neither `MemRead` nor `MemWrite`: `commit`=1, `stall`=0, next state FETCH.
  - Otherwise: `stall`=1, next state DATA.
- DATA: `bus_req`=1, `bus_we`=`MemWrite`, `bus_addr`=`ALUResult`, `bus_wdata`=`WriteData`.
  - On `bus_ack`: if `MemRead`, `ReadData`<=`bus_rdata`; go to WB.
- WB: `commit`=1, `stall`=0, next state FETCH.
- Bus outputs are combinational from the state register and inputs that are stable while in that state. `PC`, `Instr` and the register file only change on a commit edge.
- `bus_wdata`=0 and `bus_addr`=0 whenever `bus_req`=0.
- `MemRead` and `MemWrite` both 1 is illegal; it is treated as a store and `ReadData` is not updated.
- `bus_ack` is ignored in every state other than FETCH and DATA.
- An ack in the same cycle `bus_req` rises is legal (zero wait states).

## Timing
- Reset values: state IDLE, `Instr`=32'h0000_0013 (NOP), `ReadData`=0, `stall`=1, `commit`=0, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `bus_err`=0.
- Minimum latency, fetch start to commit, with zero wait states:
  - non-memory instruction: 2 cycles (FETCH, EXEC);
  - load/store: 4 cycles (FETCH, EXEC, DATA, WB).
- Each bus wait state adds one cycle to its phase.
- `commit` is exactly one cycle wide per instruction. `stall`==~`commit` in every state except IDLE and HALT, where `stall`=1.
- The PC advances on the edge that ends the commit cycle. FETCH re-enters with the new `PC`.
- Reset asserted mid-transaction: all outputs return to their reset values asynchronously, and `bus_req` drops immediately. The in-flight access is abandoned and the bus must tolerate the drop.
- After `reset_n` rises: 1 IDLE cycle, then FETCH.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8-bit wait counter clears on entry to FETCH or DATA and increments each cycle without `bus_ack`.
  - When the counter reaches `TIMEOUT_CYCLES`: `bus_req` drops, `bus_err`<=1, state goes to HALT.
  - HALT: `stall`=1, `bus_req`=0, `commit`=0. Exited only by reset.
- `MEM_TIMEOUT_EN` undefined: no counter, waits for `bus_ack` indefinitely, `bus_err` is constant 0.

## Test plan
- Reset release, `PC`=0, immediate ack with `bus_rdata`=32'h0050_0093 (addi x1,x0,5) -> `bus_req` high in cycle 1 after reset, `Instr`=32'h0050_0093 in cycle 2, `commit`=1 in cycle 2 only, `bus_addr`=4 at the next FETCH.
- Load, `ALUResult`=32'h100, ack 3 cycles late, `bus_rdata`=32'hDEAD_BEEF -> `bus_addr`=32'h100 and `bus_we`=0 held stable through the wait states, `ReadData`=32'hDEAD_BEEF during WB, exactly one `commit`.
- Store, `ALUResult`=32'h204, `WriteData`=32'h1234_5678, 2 wait states -> `bus_we`=1, `bus_wdata`=32'h1234_5678 stable until ack, `ReadData` unchanged.
- `reset_n` low during a DATA wait -> `bus_req`=0 and `stall`=1 in the same cycle, `Instr`=32'h13; after release, 1 IDLE cycle then FETCH.
- Spurious `bus_ack` during EXEC and WB -> no state or register change.
- (`MEM_TIMEOUT_EN`) no ack for 64 cycles in FETCH -> `bus_err`=1, `bus_req`=0, `stall` stays 1, no further `commit` until reset.
